// File: rtl/accu_window_ctrl_pkg.sv
// accu_pkg: shared types and sizing helpers for the window accumulator.
//   state_e     - controller state encoding
//   WIN_LEN_DEF - default samples per window
//   clog2()     - constant function used to size the sample counter
package accu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int WIN_LEN_DEF = 50;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/accu_window_ctrl_core.sv
// accu_core: signed ACC_W-wide running sum.
//   clk, rst_n : clock, async active-low reset (sum -> 0)
//   clr        : restart the sum; with add_en the sample becomes the new sum
//   add_en     : add sample to the sum
//   sample     : sign-extended operand
//   sum        : current accumulated value
module accu_core #(
  parameter int ACC_W = 38
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= add_en ? sample : '0;
    end else if (add_en) begin
      sum <= sum + sample;
    end
  end

endmodule

// File: rtl/accu_window_ctrl.sv
// accu_window_ctrl: sums fixed windows of WIN_LEN signed samples and hands
// each sum to a downstream FIFO over valid/ready, with start/stop sequencing.
//   clk, rst_n          : clock, async active-low reset
//   start, stop         : one-cycle sequencing pulses
//   in_valid/in_ready   : sample handshake, in_data signed DATA_W
//   out_valid/out_ready : result handshake, out_data signed ACC_W
//   busy                : controller not idle
//   win_count           : completed windows since reset (wraps)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | not accumulating; in_ready low; pending result still drains
// RUN      | accumulating windows back to back
// STOPPING | finishing the current window, then back to IDLE
module accu_window_ctrl
  import accu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = (clog2(WIN_LEN) < 1) ? 1 : clog2(WIN_LEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W+CNT_W-1:0]   out_data,
  output logic                      busy,
  output logic [15:0]               win_count
);

  localparam int ACC_W = DATA_W + CNT_W;

  state_e             state;
  logic [CNT_W-1:0]   sample_cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sample_ext;
  logic               cnt_last;
  logic               accept;
  logic               win_done;
  logic               xfer;
  logic               core_clr;
  logic               core_add;

  assign sample_ext = {{CNT_W{in_data[DATA_W-1]}}, in_data};
  assign cnt_last   = (sample_cnt == CNT_W'(WIN_LEN - 1));

  // The last sample of a window is held off while the result slot is still
  // occupied; this makes in_ready combinational on out_ready.
  assign in_ready = (state != IDLE) && !(cnt_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign win_done = accept && cnt_last;
  assign xfer     = out_valid && out_ready;
  assign busy     = (state != IDLE);

  assign core_clr = ((state == IDLE) && start && !stop) || win_done;
  assign core_add = accept && !cnt_last;

  accu_core #(.ACC_W(ACC_W)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (core_clr),
    .add_en (core_add),
    .sample (sample_ext),
    .sum    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) state <= RUN;
        end
        RUN: begin
          if (stop) state <= (sample_cnt == '0 && !accept) ? IDLE : STOPPING;
        end
        STOPPING: begin
          if (win_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if ((state == IDLE) && start && !stop) begin
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= cnt_last ? '0 : sample_cnt + CNT_W'(1);
    end
  end

  // A new sum may land in the same cycle the previous one transfers; the
  // load takes priority so out_valid stays high without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      win_count <= '0;
    end else begin
      if (win_done) begin
        out_data  <= acc + sample_ext;
        out_valid <= 1'b1;
        win_count <= win_count + 16'd1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accu_window_ctrl.sv
module tb_accu_window_ctrl;

  localparam int DATA_W  = 32;
  localparam int WIN_LEN = 50;
  localparam int CNT_W   = 6;
  localparam int ACC_W   = DATA_W + CNT_W;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                stop;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_data;
  logic                busy;
  logic [15:0]         win_count;

  int n_checks;
  int n_fail;
  int stall_seen;

  accu_window_ctrl #(.DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .win_count (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] sample;
    longint             exp_sum;
  } win_vec_t;

  win_vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint od();
    return longint'($signed(out_data));
  endfunction

  // Present one sample and wait (bounded) until it is accepted.
  task automatic send(input logic signed [31:0] d);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && w < 200) begin
      tick();
      #1;
      w++;
    end
    if (w > 0) stall_seen++;
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  longint       q_exp [$];
  longint       model_acc;
  int           model_cnt;
  int           n_done;
  int           cyc;
  logic         acc_now;
  logic [15:0]  wc_base;

  initial begin
    n_checks = 0; n_fail = 0; stall_seen = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    vecs[0] = '{32'sd1,          64'sd50};
    vecs[1] = '{32'sh8000_0000, -64'sd107374182400};
    vecs[2] = '{32'sd3,          64'sd150};
    vecs[3] = '{32'sd2,          64'sd100};
    vecs[4] = '{-32'sd1,        -64'sd50};
    vecs[5] = '{32'sh7fff_ffff,  64'sd107374182350};

    // Reset values
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", od(), 0);
    check("rst_win_count", win_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Table-driven back-to-back windows, out_ready held high
    pulse_start();
    check("run_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < WIN_LEN - 1; k++) send(vecs[i].sample);
      if (i == 0) check("no_early_valid", out_valid, 0);
      send(vecs[i].sample);
      check("win_valid", out_valid, 1);
      check("win_sum", od(), vecs[i].exp_sum);
      check("win_count", win_count, i + 1);
    end
    check("no_stall_b2b", stall_seen, 0);
    tick();
    check("drain_alone", out_valid, 0);

    // Backpressure: second window's last sample waits for the slot
    out_ready = 1'b0;
    for (int k = 0; k < WIN_LEN; k++) send(32'sd1);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_sum", od(), 50);
    for (int k = 0; k < WIN_LEN - 1; k++) send(32'sd1);
    in_valid = 1'b1; in_data = 32'sd1;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    tick(); tick();
    #1;
    check("bp_held_valid", out_valid, 1);
    check("bp_held_sum", od(), 50);
    check("bp_still_low", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_sum", od(), 50);
    check("bp_count", win_count, 8);
    tick();
    check("bp_drained", out_valid, 0);

    // Stop mid-window: finish the window, then idle
    for (int k = 0; k < 20; k++) send(32'sd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopping_busy", busy, 1);
    pulse_start();
    for (int k = 0; k < 30; k++) send(32'sd5);
    check("stop_win_valid", out_valid, 1);
    check("stop_win_sum", od(), 250);
    check("stop_idle_busy", busy, 0);
    check("stop_idle_in_ready", in_ready, 0);
    check("stop_count", win_count, 9);
    tick();
    check("idle_drained", out_valid, 0);

    // Stop at window boundary: idle next cycle, no output
    pulse_start();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop0_busy", busy, 0);
    check("stop0_valid", out_valid, 0);
    check("stop0_count", win_count, 9);

    // start && stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);

    // Asynchronous reset mid-window with a pending result
    pulse_start();
    out_ready = 1'b0;
    for (int k = 0; k < WIN_LEN; k++) send(32'sd1);
    for (int k = 0; k < 30; k++) send(32'sd1);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_count", win_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    pulse_start();
    for (int k = 0; k < WIN_LEN; k++) send(32'sd2);
    check("post_rst_sum", od(), 100);
    check("post_rst_count", win_count, 1);
    tick();

    // Random bubbles and backpressure against a reference sum
    wc_base = win_count;
    model_acc = 0; model_cnt = 0; n_done = 0; cyc = 0;
    while ((n_done < 20 || q_exp.size() > 0 || out_valid) && cyc < 5000) begin
      in_valid  = (n_done < 20) ? ($urandom_range(0, 3) != 0) : 1'b0;
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          check("rnd_unexpected_out", out_valid, 0);
        end else begin
          check("rnd_sum", od(), q_exp.pop_front());
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        model_acc += longint'($signed(in_data));
        model_cnt++;
        if (model_cnt == WIN_LEN) begin
          q_exp.push_back(model_acc);
          model_acc = 0;
          model_cnt = 0;
          n_done++;
        end
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_finished", cyc < 5000, 1);
    check("rnd_count", win_count, wc_base + 16'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accu_window_ctrl.md
Name: accu_window_ctrl

Overview:
Window scheduler and sequencer for the feature accumulator. It accepts a signed sample stream with a valid/ready handshake and sums fixed windows of WIN_LEN samples. Each completed window sum is presented to the downstream FIFO on a valid/ready output port, with backpressure. The block sits between the feature extraction stage and the result FIFO, and replaces free-running accumulator use with explicit start/stop sequencing.

Parameters:
DATA_W, 32, width of the signed input sample
WIN_LEN, 50, samples per window; legal range 2..63
CNT_W, 6, sample counter width; ceil(log2(WIN_LEN)), at least 1
ACC_W, DATA_W+CNT_W (38), accumulator and result width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse that begins windowed accumulation
stop  in  1  one-cycle pulse that ends accumulation after the current window
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  DATA_W  signed sample
out_valid  out  1  out_data holds a completed window sum
out_ready  in  1  downstream accepts out_data
out_data  out  ACC_W  signed window sum
busy  out  1  state is not IDLE
win_count  out  16  completed windows since reset; wraps modulo 2^16

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, acc 0, sample_cnt 0, out_valid 0, out_data 0, win_count 0, in_ready 0, busy 0.
- FSM states: IDLE, RUN, STOPPING.
- Accept event: in_valid && in_ready on a rising edge.
- IDLE:
  - in_ready = 0.
  - start && !stop: go to RUN; acc <= 0; sample_cnt <= 0.
  - start && stop in the same cycle: stop wins; stay in IDLE.
  - stop alone: no effect.
- RUN and STOPPING, input side:
  - in_ready = 1, except when sample_cnt == WIN_LEN-1 && out_valid && !out_ready. The last sample of a window stalls until the result slot is free.
  - On accept with sample_cnt < WIN_LEN-1: acc <= acc + sext(in_data); sample_cnt++.
  - On accept with sample_cnt == WIN_LEN-1 (window complete):
    - out_data <= acc + sext(in_data); out_valid <= 1 (visible the cycle after the last accept);
    - acc <= 0; sample_cnt <= 0; win_count++.
- RUN, stop handling:
  - stop with sample_cnt == 0 and no accept this cycle: go to IDLE next cycle.
  - stop otherwise: go to STOPPING.
  - start is ignored in RUN.
- STOPPING: behaves as RUN; on window complete go to IDLE. start and stop are ignored. Partial windows are never emitted.
- Output side:
  - out_valid holds, and out_data stays stable, until out_valid && out_ready.
  - Transfer and a new window completing in the same cycle: out_data loads the new sum and out_valid stays 1.
  - Transfer alone: out_valid <= 0.
  - Output behaviour is the same in every state, including IDLE (a pending result drains after stop).
- Arithmetic: two's-complement sign extension of in_data to ACC_W. ACC_W guarantees no overflow for WIN_LEN ≤ 2^CNT_W.
- busy = (state != IDLE). The handshake is fully synchronous apart from reset; in_ready depends combinationally on out_ready (documented path).
- Reset mid-window: the partial sum and any pending output are discarded immediately (out_valid drops asynchronously).

Decomposition:
- Package accu_pkg:
  - state enum {IDLE, RUN, STOPPING};
  - default WIN_LEN = 50;
  - clog2 constant function used to derive CNT_W and ACC_W.
- Sub-module accu_core: ACC_W-wide signed accumulator.
  - Inputs: clr, add_en, sext sample.
  - Output: current sum.
  - Asynchronous active-low reset.
  - clr has priority over add_en; clr with add_en loads the sample.
- The FSM, counter and output register stay in accu_window_ctrl.

Test Plan:
1. Reset, start, 50 samples of +1 back-to-back with out_ready=1 -> out_valid=1 exactly one cycle after the 50th accept; out_data=50; win_count=1; in_ready stays 1.
2. 50 samples of -2^31 -> out_data = -107374182400 (38-bit signed, no wrap); next window of +3 -> out_data=150.
3. out_ready=0, feed 100 samples of 1 -> first result 50 held; in_ready=0 at sample_cnt=49 of window 2; raise out_ready -> 49th-index sample accepted; out_data=50 then 50; no sample lost.
4. stop at sample_cnt=20 -> state STOPPING, 30 more accepts, window emitted, state IDLE, in_ready=0, busy=0. stop at sample_cnt=0 -> IDLE next cycle, no output. start && stop in IDLE -> remain IDLE.
5. rst_n low at sample_cnt=30 with out_valid=1 -> out_valid, in_ready, busy drop immediately. After rst_n high and start, 50 samples of 2 -> out_data=100, win_count=1.
6. Random in_valid bubbles and random out_ready over 20 windows of random samples -> every out_data matches the reference-model window sum; win_count=20.
